i2c_target_ssd1306: RTL and testbench

I2C_TARGET_SSD1306 -- requirements
Module: i2c_target_ssd1306

---
 rtl/i2c_target_ssd1306.sv | 198 +++++++++++++++++++
 tb/tb_i2c_target_ssd1306.sv | 237 +++++++++++++++++++++++
 2 files changed

// File: rtl/i2c_target_ssd1306.sv
// -----------------------------------------------------------------------------
// i2c_target_ssd1306
// Write-only I2C target that speaks the SSD1306 display-controller protocol.
// After its address is matched it reads one control byte (Co, D/C#) and then
// hands out payload bytes, each tagged as GDDRAM data or as a command.
// Everything runs in the Clock domain. The raw bus lines are oversampled
// through a synchronizer, so Clock must be several times faster than SCL.
//
// Ports
//   Clock          in   system clock, rising edge
//   cReset         in   asynchronous active-high reset
//   cSCL           in   raw bus SCL level
//   cSDA           in   raw bus SDA level (resolved open-drain value)
//   cSDADriverLow  out  1 pulls SDA low (ACK), 0 releases SDA
//   RxData         out  last received payload byte
//   RxDataValid    out  one-Clock pulse when RxData is updated
//   RxIsData       out  D/C# qualifier for RxData (1 = GDDRAM data, 0 = command)
//   BusBusy        out  1 from a START until the following STOP
// -----------------------------------------------------------------------------
module i2c_target_ssd1306 #(
   parameter logic [6:0] SLAVE_ADDRESS = 7'b0111100,
   parameter int         SYNC_STAGES   = 2
) (
   input  logic       Clock,
   input  logic       cReset,
   input  logic       cSCL,
   input  logic       cSDA,
   output logic       cSDADriverLow,
   output logic [7:0] RxData,
   output logic       RxDataValid,
   output logic       RxIsData,
   output logic       BusBusy
);

   // One-hot state encoding; any illegal pattern falls back to IDLE.
   typedef enum logic [7:0] {
      IDLE     = 8'b0000_0001,
      ADDR     = 8'b0000_0010,
      ADDR_ACK = 8'b0000_0100,
      CTRL     = 8'b0000_1000,
      CTRL_ACK = 8'b0001_0000,
      DATA     = 8'b0010_0000,
      DATA_ACK = 8'b0100_0000,
      IGNORE   = 8'b1000_0000
   } state_t;

   logic [SYNC_STAGES-1:0] sclSync_r;
   logic [SYNC_STAGES-1:0] sdaSync_r;
   logic                   sclDly_r;
   logic                   sdaDly_r;

   logic                   sScl_s;
   logic                   sSda_s;
   logic                   sclRise_s;
   logic                   sclFall_s;
   logic                   startDet_s;
   logic                   stopDet_s;

   state_t                 state_r;
   state_t                 afterAck_s;
   logic [3:0]             bitCnt_r;
   logic [7:0]             shift_r;
   logic [7:0]             nextShift_s;
   logic                   addrMatch_s;
   logic                   co_r;
   logic                   dc_r;

   // Bus line synchronizers; reset to 1 so the bus looks idle.
   always_ff @(posedge Clock or posedge cReset) begin
      if (cReset) begin
         sclSync_r <= {SYNC_STAGES{1'b1}};
         sdaSync_r <= {SYNC_STAGES{1'b1}};
         sclDly_r  <= 1'b1;
         sdaDly_r  <= 1'b1;
      end else begin
         sclSync_r <= {sclSync_r[SYNC_STAGES-2:0], cSCL};
         sdaSync_r <= {sdaSync_r[SYNC_STAGES-2:0], cSDA};
         sclDly_r  <= sclSync_r[SYNC_STAGES-1];
         sdaDly_r  <= sdaSync_r[SYNC_STAGES-1];
      end
   end

   assign sScl_s    = sclSync_r[SYNC_STAGES-1];
   assign sSda_s    = sdaSync_r[SYNC_STAGES-1];
   assign sclRise_s =  sScl_s & ~sclDly_r;
   assign sclFall_s = ~sScl_s &  sclDly_r;

   // SCL must be high in both the current and the previous sample, so an SDA
   // change that coincides with an SCL edge is never mistaken for START/STOP.
   assign startDet_s = sScl_s & sclDly_r &  sdaDly_r & ~sSda_s;
   assign stopDet_s  = sScl_s & sclDly_r & ~sdaDly_r &  sSda_s;

   // Byte as it will look once the bit being sampled now is shifted in.
   assign nextShift_s = {shift_r[6:0], sSda_s};

   // Only writes to our own address are acknowledged; reads are NACKed.
   assign addrMatch_s = (nextShift_s[7:1] == SLAVE_ADDRESS) && (nextShift_s[0] == 1'b0);

   // Where to go once the ACK clock has completed.
   always_comb begin
      afterAck_s = IDLE;
      case (state_r)
         ADDR_ACK: afterAck_s = CTRL;
         CTRL_ACK: afterAck_s = DATA;
         DATA_ACK: afterAck_s = co_r ? CTRL : DATA;
         default:  afterAck_s = IDLE;
      endcase
   end

   // Protocol FSM with registered outputs; START/STOP outrank SCL edges.
   always_ff @(posedge Clock or posedge cReset) begin
      if (cReset) begin
         state_r       <= IDLE;
         bitCnt_r      <= 4'd0;
         shift_r       <= 8'h00;
         co_r          <= 1'b0;
         dc_r          <= 1'b0;
         cSDADriverLow <= 1'b0;
         RxData        <= 8'h00;
         RxDataValid   <= 1'b0;
         RxIsData      <= 1'b0;
         BusBusy       <= 1'b0;
      end else begin
         RxDataValid <= 1'b0;
         if (startDet_s) begin
            // START or repeated START: abandon any partial byte.
            state_r       <= ADDR;
            bitCnt_r      <= 4'd0;
            shift_r       <= 8'h00;
            cSDADriverLow <= 1'b0;
            BusBusy       <= 1'b1;
         end else if (stopDet_s) begin
            state_r       <= IDLE;
            bitCnt_r      <= 4'd0;
            shift_r       <= 8'h00;
            cSDADriverLow <= 1'b0;
            BusBusy       <= 1'b0;
         end else begin
            case (state_r)
               IDLE: begin
                  state_r <= IDLE;
               end
               ADDR, CTRL, DATA: begin
                  if (sclRise_s) begin
                     shift_r <= nextShift_s;
                     if (bitCnt_r >= 4'd7) begin
                        // Eighth bit: the counter parks at 8 until the ACK ends.
                        bitCnt_r <= 4'd8;
                        if (state_r == ADDR) begin
                           state_r <= addrMatch_s ? ADDR_ACK : IGNORE;
                        end else if (state_r == CTRL) begin
                           co_r    <= nextShift_s[7];
                           dc_r    <= nextShift_s[6];
                           state_r <= CTRL_ACK;
                        end else begin
                           RxData      <= nextShift_s;
                           RxIsData    <= dc_r;
                           RxDataValid <= 1'b1;
                           state_r     <= DATA_ACK;
                        end
                     end else begin
                        bitCnt_r <= bitCnt_r + 4'd1;
                     end
                  end else begin
                     state_r <= state_r;
                  end
               end
               ADDR_ACK, CTRL_ACK, DATA_ACK: begin
                  // First SCL fall after bit 8 pulls SDA low for the ACK
                  // clock; the next SCL fall releases it and starts a byte.
                  if (sclFall_s) begin
                     if (!cSDADriverLow) begin
                        cSDADriverLow <= 1'b1;
                     end else begin
                        cSDADriverLow <= 1'b0;
                        bitCnt_r      <= 4'd0;
                        shift_r       <= 8'h00;
                        state_r       <= afterAck_s;
                     end
                  end else begin
                     state_r <= state_r;
                  end
               end
               IGNORE: begin
                  state_r <= IGNORE;
               end
               default: begin
                  state_r       <= IDLE;
                  bitCnt_r      <= 4'd0;
                  shift_r       <= 8'h00;
                  cSDADriverLow <= 1'b0;
               end
            endcase
         end
      end
   end

endmodule

// File: tb/tb_i2c_target_ssd1306.sv
// -----------------------------------------------------------------------------
// tb_i2c_target_ssd1306
// Bench for i2c_target_ssd1306: a bit-banged I2C master drives the bus,
// expected payload bytes go into a scoreboard queue as they are sent and are
// popped when the target pulses RxDataValid. ACKs are sampled during the
// ninth SCL high phase and also counted per transaction.
// -----------------------------------------------------------------------------
module tb_i2c_target_ssd1306;

   localparam int Q = 6;   // Clock cycles SCL low before/after a data change
   localparam int H = 12;  // Clock cycles SCL high

   logic       Clock = 1'b0;
   logic       cReset = 1'b1;
   logic       sclM = 1'b1;
   logic       sdaM = 1'b1;
   logic       busSda;
   logic       cSDADriverLow;
   logic [7:0] RxData;
   logic       RxDataValid;
   logic       RxIsData;
   logic       BusBusy;

   int         compareCount = 0;
   int         mismatchCount = 0;
   int         ackCount = 0;
   int         ackBase;
   logic       prevDrv = 1'b0;
   logic       prevValid = 1'b0;
   logic [8:0] expQ[$];
   logic [8:0] expItem;

   // Open-drain bus: either side can pull SDA low.
   assign busSda = sdaM & ~cSDADriverLow;

   i2c_target_ssd1306 dut (
      .Clock         (Clock),
      .cReset        (cReset),
      .cSCL          (sclM),
      .cSDA          (busSda),
      .cSDADriverLow (cSDADriverLow),
      .RxData        (RxData),
      .RxDataValid   (RxDataValid),
      .RxIsData      (RxIsData),
      .BusBusy       (BusBusy)
   );

   always #5 Clock = ~Clock;

   task automatic checkEq(input string tag, input logic [31:0] got, input logic [31:0] exp);
      compareCount++;
      if (got !== exp) begin
         mismatchCount++;
         $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
      end
   endtask

   task automatic waitClk(input int n);
      repeat (n) @(negedge Clock);
   endtask

   task automatic i2cStart();
      sdaM = 1'b1;
      waitClk(Q);
      sclM = 1'b1;
      waitClk(H);
      sdaM = 1'b0;
      waitClk(H);
      sclM = 1'b0;
      waitClk(Q);
      checkEq("busyAfterStart", BusBusy, 1);
   endtask

   task automatic i2cStop();
      sdaM = 1'b0;
      waitClk(Q);
      sclM = 1'b1;
      waitClk(H);
      sdaM = 1'b1;
      waitClk(H);
      checkEq("busyAfterStop", BusBusy, 0);
      checkEq("drvAfterStop", cSDADriverLow, 0);
   endtask

   task automatic sendBits(input logic [7:0] b, input int n);
      for (int i = 0; i < n; i++) begin
         sdaM = b[7-i];
         waitClk(Q);
         sclM = 1'b1;
         waitClk(H);
         sclM = 1'b0;
         waitClk(Q);
      end
   endtask

   task automatic ackBit(input logic expAck);
      sdaM = 1'b1;
      waitClk(Q);
      sclM = 1'b1;
      waitClk(H/2);
      checkEq("ackLevel", cSDADriverLow, expAck);
      waitClk(H/2);
      sclM = 1'b0;
      waitClk(Q);
      checkEq("ackRelease", cSDADriverLow, 0);
   endtask

   task automatic sendByte(input logic [7:0] b, input logic expAck);
      sendBits(b, 8);
      ackBit(expAck);
   endtask

   // Scoreboard side: pop and compare on every RxDataValid pulse.
   always @(negedge Clock) begin
      if (cSDADriverLow && !prevDrv) ackCount++;
      prevDrv = cSDADriverLow;
      if (RxDataValid) begin
         checkEq("validPulseLen", prevValid, 0);
         if (expQ.size() == 0) begin
            checkEq("unexpectedValid", RxDataValid, 0);
         end else begin
            expItem = expQ.pop_front();
            checkEq("rxData", RxData, expItem[7:0]);
            checkEq("rxIsData", RxIsData, expItem[8]);
         end
      end
      prevValid = RxDataValid;
   end

   initial begin
      // Reset state
      waitClk(4);
      checkEq("rstDrv", cSDADriverLow, 0);
      checkEq("rstValid", RxDataValid, 0);
      checkEq("rstData", RxData, 8'h00);
      checkEq("rstIsData", RxIsData, 0);
      checkEq("rstBusy", BusBusy, 0);
      cReset = 1'b0;
      waitClk(4);

      // Single command byte
      ackBase = ackCount;
      i2cStart();
      sendByte(8'h78, 1'b1);
      sendByte(8'h00, 1'b1);
      expQ.push_back({1'b0, 8'hAE});
      sendByte(8'hAE, 1'b1);
      i2cStop();
      checkEq("acks30", ackCount - ackBase, 3);
      checkEq("hold30", RxData, 8'hAE);

      // Wrong address: no ACK, no payload
      ackBase = ackCount;
      i2cStart();
      sendByte(8'h7A, 1'b0);
      sendByte(8'h00, 1'b0);
      i2cStop();
      checkEq("acks31", ackCount - ackBase, 0);
      checkEq("hold31", RxData, 8'hAE);

      // Data stream
      ackBase = ackCount;
      i2cStart();
      sendByte(8'h78, 1'b1);
      sendByte(8'h40, 1'b1);
      expQ.push_back({1'b1, 8'hFF});
      sendByte(8'hFF, 1'b1);
      expQ.push_back({1'b1, 8'h01});
      sendByte(8'h01, 1'b1);
      i2cStop();
      checkEq("acks32", ackCount - ackBase, 4);

      // Co=1: control byte before every payload byte
      ackBase = ackCount;
      i2cStart();
      sendByte(8'h78, 1'b1);
      sendByte(8'h80, 1'b1);
      expQ.push_back({1'b0, 8'hA5});
      sendByte(8'hA5, 1'b1);
      sendByte(8'hC0, 1'b1);
      expQ.push_back({1'b1, 8'h12});
      sendByte(8'h12, 1'b1);
      i2cStop();
      checkEq("acks33", ackCount - ackBase, 5);

      // Repeated START mid-byte, then a read address
      ackBase = ackCount;
      i2cStart();
      sendByte(8'h78, 1'b1);
      sendByte(8'h00, 1'b1);
      sendBits(8'hA0, 4);
      i2cStart();
      sendByte(8'h78, 1'b1);
      sendByte(8'h00, 1'b1);
      expQ.push_back({1'b0, 8'h8D});
      sendByte(8'h8D, 1'b1);
      i2cStart();
      sendByte(8'h79, 1'b0);
      i2cStop();
      checkEq("acks34", ackCount - ackBase, 5);

      // Reset while the target is driving an ACK
      i2cStart();
      sendBits(8'h78, 8);
      checkEq("ackBeforeReset", cSDADriverLow, 1);
      @(negedge Clock);
      #2;
      cReset = 1'b1;
      #1;
      checkEq("rstAsyncRelease", cSDADriverLow, 0);
      waitClk(3);
      checkEq("rstMidBusy", BusBusy, 0);
      checkEq("rstMidData", RxData, 8'h00);
      cReset = 1'b0;
      waitClk(3);
      // Traffic without a START is ignored after reset
      ackBase = ackCount;
      sendByte(8'h78, 1'b0);
      sendByte(8'h00, 1'b0);
      i2cStop();
      checkEq("acksNoStart", ackCount - ackBase, 0);
      ackBase = ackCount;
      i2cStart();
      sendByte(8'h78, 1'b1);
      sendByte(8'h00, 1'b1);
      expQ.push_back({1'b0, 8'hAF});
      sendByte(8'hAF, 1'b1);
      i2cStop();
      checkEq("acks35", ackCount - ackBase, 3);

      waitClk(10);
      checkEq("scoreboardEmpty", expQ.size(), 0);
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", compareCount, mismatchCount);
      $finish;
   end

endmodule
